// File: rtl/pipe_delay_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_delay_reg : delays a WIDTH-bit scalar / 1-D / 2-D array by PIPE_DEPTH
//                  enabled clock edges; PIPE_DELAY_REG_CHECK_EN adds sim checks.
// Revision       : 1.0
// ----------------------------------------------------------------------------
module pipe_delay_reg #(
  parameter int WIDTH         = 1,
  parameter int ARRAY_SIZE1   = 1,
  parameter int ARRAY_SIZE2   = 1,
  parameter int PIPE_DEPTH    = 1,
  parameter int RETIME_STATUS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] in  [ARRAY_SIZE1][ARRAY_SIZE2],
  output logic [WIDTH-1:0] out [ARRAY_SIZE1][ARRAY_SIZE2]
);

  generate
    if (PIPE_DEPTH == 0) begin : g_passthru
      // Pure wiring: clock, reset and enable are intentionally ignored.
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset ^ en;

      for (genvar i = 0; i < ARRAY_SIZE1; i++) begin : g_i
        for (genvar j = 0; j < ARRAY_SIZE2; j++) begin : g_j
          assign out[i][j] = in[i][j];
        end
      end
    end else begin : g_pipe
      // chain[s] feeds stage s; chain[PIPE_DEPTH] is the last stage output.
      logic [WIDTH-1:0] chain [PIPE_DEPTH+1][ARRAY_SIZE1][ARRAY_SIZE2];

      for (genvar i = 0; i < ARRAY_SIZE1; i++) begin : g_i
        for (genvar j = 0; j < ARRAY_SIZE2; j++) begin : g_j
          assign chain[0][i][j] = in[i][j];
          assign out[i][j]      = chain[PIPE_DEPTH][i][j];
        end
      end

      for (genvar s = 0; s < PIPE_DEPTH; s++) begin : g_stage
        logic [WIDTH-1:0] stage_d [ARRAY_SIZE1][ARRAY_SIZE2];
        logic [WIDTH-1:0] stage_q [ARRAY_SIZE1][ARRAY_SIZE2];

        for (genvar i = 0; i < ARRAY_SIZE1; i++) begin : g_i
          for (genvar j = 0; j < ARRAY_SIZE2; j++) begin : g_j
            assign stage_d[i][j]      = en ? chain[s][i][j] : stage_q[i][j];
            assign chain[s+1][i][j]   = stage_q[i][j];
          end
        end

        if (RETIME_STATUS != 0) begin : g_retime
          (* retiming_allowed = "true" *)
          always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
              for (int i = 0; i < ARRAY_SIZE1; i++)
                for (int j = 0; j < ARRAY_SIZE2; j++)
                  stage_q[i][j] <= '0;
            end else begin
              for (int i = 0; i < ARRAY_SIZE1; i++)
                for (int j = 0; j < ARRAY_SIZE2; j++)
                  stage_q[i][j] <= stage_d[i][j];
            end
          end
        end else begin : g_fixed
          always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
              for (int i = 0; i < ARRAY_SIZE1; i++)
                for (int j = 0; j < ARRAY_SIZE2; j++)
                  stage_q[i][j] <= '0;
            end else begin
              for (int i = 0; i < ARRAY_SIZE1; i++)
                for (int j = 0; j < ARRAY_SIZE2; j++)
                  stage_q[i][j] <= stage_d[i][j];
            end
          end
        end
      end
    end
  endgenerate

`ifdef PIPE_DELAY_REG_CHECK_EN
  if (WIDTH < 1 || ARRAY_SIZE1 < 1 || ARRAY_SIZE2 < 1 || PIPE_DEPTH < 0 ||
      (RETIME_STATUS != 0 && RETIME_STATUS != 1)) begin : g_bad_param
    $fatal(1, "pipe_delay_reg: illegal parameter value");
  end

  logic seen_edge_q;
  always_ff @(posedge clk) seen_edge_q <= 1'b1;

  always @(posedge clk) begin
    if (seen_edge_q === 1'b1 && ($isunknown(en) || $isunknown(reset)))
      $warning("pipe_delay_reg: en or reset is X/Z");
  end

  if (PIPE_DEPTH >= 1) begin : g_chk_latency
    // Counts enabled edges since reset so the check starts once the pipe is full.
    int fill_q;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          fill_q <= 0;
      else if (en && fill_q < PIPE_DEPTH)  fill_q <= fill_q + 1;
    end

    for (genvar i = 0; i < ARRAY_SIZE1; i++) begin : g_i
      for (genvar j = 0; j < ARRAY_SIZE2; j++) begin : g_j
        a_latency: assert property (@(posedge clk) disable iff (!reset)
          (en && fill_q >= PIPE_DEPTH) |-> (out[i][j] === $past(in[i][j], PIPE_DEPTH, en)));
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_delay_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_delay_reg : directed self-checking bench for pipe_delay_reg shapes.
// Revision          : 1.0
// ----------------------------------------------------------------------------
module tb_pipe_delay_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [23:0] fa(int c, int i, int j);
    return 24'(32'h100 * (c + 1) + 3 * i + j);
  endfunction

  // depth 3, 3x3 x 24
  logic        rst_a, en_a;
  logic [23:0] in_a [3][3];
  logic [23:0] out_a [3][3];
  // depth 2, scalar x 8
  logic        rst_b, en_b;
  logic [7:0]  in_b [1][1];
  logic [7:0]  out_b [1][1];
  // depth 0, 1-D size 3 x 8
  logic        rst_c, en_c;
  logic [7:0]  in_c [3][1];
  logic [7:0]  out_c [3][1];
  // depth 1 counter x 32
  logic        rst_d, en_d;
  logic [31:0] cnt_in [1][1];
  logic [31:0] cnt_out [1][1];
  // depth 3 scalar x 1, retimed and fixed
  logic        rst_e, en_e;
  logic [0:0]  in_e [1][1];
  logic [0:0]  out_e1 [1][1];
  logic [0:0]  out_e0 [1][1];

  assign cnt_in[0][0] = cnt_out[0][0] + 32'd1;

  pipe_delay_reg #(.WIDTH(24), .ARRAY_SIZE1(3), .ARRAY_SIZE2(3), .PIPE_DEPTH(3), .RETIME_STATUS(0))
    u_d3 (.clk(clk), .reset(rst_a), .en(en_a), .in(in_a), .out(out_a));
  pipe_delay_reg #(.WIDTH(8), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(2), .RETIME_STATUS(0))
    u_d2 (.clk(clk), .reset(rst_b), .en(en_b), .in(in_b), .out(out_b));
  pipe_delay_reg #(.WIDTH(8), .ARRAY_SIZE1(3), .ARRAY_SIZE2(1), .PIPE_DEPTH(0), .RETIME_STATUS(0))
    u_d0 (.clk(clk), .reset(rst_c), .en(en_c), .in(in_c), .out(out_c));
  pipe_delay_reg #(.WIDTH(32), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(1), .RETIME_STATUS(0))
    u_cnt (.clk(clk), .reset(rst_d), .en(en_d), .in(cnt_in), .out(cnt_out));
  pipe_delay_reg #(.WIDTH(1), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(3), .RETIME_STATUS(1))
    u_s1 (.clk(clk), .reset(rst_e), .en(en_e), .in(in_e), .out(out_e1));
  pipe_delay_reg #(.WIDTH(1), .ARRAY_SIZE1(1), .ARRAY_SIZE2(1), .PIPE_DEPTH(3), .RETIME_STATUS(0))
    u_s0 (.clk(clk), .reset(rst_e), .en(en_e), .in(in_e), .out(out_e0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0; rst_e = 1'b0;
    en_a  = 1'b0; en_b  = 1'b0; en_c  = 1'b0; en_d  = 1'b0; en_e  = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) in_a[i][j] = 24'h0;
    in_b[0][0] = 8'h0;
    for (int i = 0; i < 3; i++) in_c[i][0] = 8'h0;
    in_e[0][0] = 1'b0;
    #1;

    // Reset state
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("d3_reset[%0d][%0d]", i, j), 32'(out_a[i][j]), 32'h0);
    chk("d2_reset", 32'(out_b[0][0]), 32'h0);
    chk("cnt_reset", cnt_out[0][0], 32'h0);
    chk("s1_reset", 32'(out_e1[0][0]), 32'h0);
    chk("s0_reset", 32'(out_e0[0][0]), 32'h0);

    // Depth 0: combinational, reset has no effect
    in_c[0][0] = 8'h11; in_c[1][0] = 8'h22; in_c[2][0] = 8'h33;
    #1;
    chk("d0_in_rst[0]", 32'(out_c[0][0]), 32'h11);
    chk("d0_in_rst[1]", 32'(out_c[1][0]), 32'h22);
    chk("d0_in_rst[2]", 32'(out_c[2][0]), 32'h33);
    rst_c = 1'b1;
    in_c[0][0] = 8'h44; in_c[1][0] = 8'h55; in_c[2][0] = 8'h66;
    #1;
    chk("d0_run[0]", 32'(out_c[0][0]), 32'h44);
    chk("d0_run[1]", 32'(out_c[1][0]), 32'h55);
    chk("d0_run[2]", 32'(out_c[2][0]), 32'h66);

    // Depth 3, 3x3 streaming
    step();
    rst_a = 1'b1; en_a = 1'b1;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) in_a[i][j] = fa(c, i, j);
      step();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("d3_c%0d[%0d][%0d]", c, i, j), 32'(out_a[i][j]),
              (c >= 2) ? 32'(fa(c - 2, i, j)) : 32'h0);
    end

    // Async reset mid-flight
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) in_a[i][j] = 24'hABCDEF;
    #2;
    rst_a = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("d3_async[%0d][%0d]", i, j), 32'(out_a[i][j]), 32'h0);
    #1;
    rst_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          chk($sformatf("d3_drain%0d[%0d][%0d]", k, i, j), 32'(out_a[i][j]),
              (k == 2) ? 32'hABCDEF : 32'h0);
    end
    en_a = 1'b0;

    // Depth 2 enable stall
    rst_b = 1'b1; en_b = 1'b1; in_b[0][0] = 8'd5;
    step(); chk("d2_pushA", 32'(out_b[0][0]), 32'd0);
    in_b[0][0] = 8'd7;
    step(); chk("d2_pushB", 32'(out_b[0][0]), 32'd5);
    en_b = 1'b0; in_b[0][0] = 8'd9;
    for (int k = 0; k < 4; k++) begin
      step(); chk($sformatf("d2_stall%0d", k), 32'(out_b[0][0]), 32'd5);
    end
    en_b = 1'b1; in_b[0][0] = 8'd0;
    step(); chk("d2_resumeB", 32'(out_b[0][0]), 32'd7);
    step(); chk("d2_resume0", 32'(out_b[0][0]), 32'd0);

    // Counter loop, depth 1
    rst_d = 1'b1; en_d = 1'b1;
    chk("cnt_start", cnt_out[0][0], 32'd0);
    for (int k = 1; k <= 9; k++) begin
      step(); chk($sformatf("cnt_%0d", k), cnt_out[0][0], 32'(k));
    end
    #2;
    rst_d = 1'b0;
    #1;
    chk("cnt_async_rst", cnt_out[0][0], 32'd0);
    step(); chk("cnt_held_rst", cnt_out[0][0], 32'd0);
    rst_d = 1'b1;
    step(); chk("cnt_restart", cnt_out[0][0], 32'd1);

    // Scalar pulse, depth 3, both retime settings
    rst_e = 1'b1; en_e = 1'b1; in_e[0][0] = 1'b1;
    step();
    in_e[0][0] = 1'b0;
    chk("s1_e0", 32'(out_e1[0][0]), 32'd0);
    chk("s0_e0", 32'(out_e0[0][0]), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("s1_e%0d", k), 32'(out_e1[0][0]), (k == 2) ? 32'd1 : 32'd0);
      chk($sformatf("s0_e%0d", k), 32'(out_e0[0][0]), (k == 2) ? 32'd1 : 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
